// File: rtl/pt_rx_decoder_if.sv
// PT2262 receive bundle: serial line in, decoded word and strobes out.
// master = line driver / word consumer, slave = decoder.
interface pt_rx_decoder_if;
  logic        din;
  logic [23:0] code;
  logic        valid;
  logic        err;

  modport master (
    output din,
    input  code,
    input  valid,
    input  err
  );

  modport slave (
    input  din,
    output code,
    output valid,
    output err
  );
endinterface

// File: rtl/pt_rx_decoder.sv
// PT2262 tri-state word receiver: pulse-width decode, double-word validate.
// Ports: clk, reset (sync, active low), bus.din in; bus.code/valid/err out.
module pt_rx_decoder #(
  parameter int ALPHA = 16,
  parameter int CW    = $clog2(64*ALPHA)+1
) (
  input  logic             clk,
  input  logic             reset,
  pt_rx_decoder_if.slave   bus
);

  typedef enum logic [2:0] {
    SEEK, ARMED, HIGH, LOW, WORD
  } state_t;

  typedef enum logic [1:0] {
    C_BAD, C_SHORT, C_LONG
  } cls_t;

  localparam logic [CW-1:0] W2   = CW'(2*ALPHA);
  localparam logic [CW-1:0] W8   = CW'(8*ALPHA);
  localparam logic [CW-1:0] W16  = CW'(16*ALPHA);
  localparam logic [CW-1:0] W64  = CW'(64*ALPHA);
  localparam logic [CW-1:0] CMAX = '1;

  logic          s1_q, ds_q, dsp_q;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  cls_t          hcls_q, hcls_d;
  logic          hb_q, hb_d;
  logic [23:0]   word_q, word_d;
  logic [23:0]   prev_word_q, prev_word_d;
  logic          prev_ok_q, prev_ok_d;
  logic [23:0]   code_q, code_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  logic rise, fall, sync_ev, lo_to;
  logic half, pulse_ok, fail;
  cls_t cur_cls;

  function automatic cls_t classify(logic [CW-1:0] w);
    cls_t c;
    c = C_BAD;
    unique case (1'b1)
      (w >= W2 && w < W8):  c = C_SHORT;
      (w >= W8 && w < W16): c = C_LONG;
      default:              c = C_BAD;
    endcase
    return c;
  endfunction

  assign rise = ds_q & ~dsp_q;
  assign fall = ~ds_q & dsp_q;

  // cnt only passes each value once per steady low, so these fire once.
  assign sync_ev = ~ds_q & ~fall & (cnt_q == W64);
  assign lo_to   = ~ds_q & ~fall & (cnt_q == W16);

  assign cur_cls  = classify(cnt_q);
  assign half     = (hcls_q == C_LONG);
  assign pulse_ok =
    (hcls_q == C_SHORT && cur_cls == C_LONG) ||
    (hcls_q == C_LONG  && cur_cls == C_SHORT);

  always_comb begin
    cnt_d = cnt_q;
    if (rise | fall)
      cnt_d = CW'(1);
    else if (cnt_q != CMAX)
      cnt_d = cnt_q + CW'(1);
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hcls_d      = hcls_q;
    hb_d        = hb_q;
    word_d      = word_q;
    prev_word_d = prev_word_q;
    prev_ok_d   = prev_ok_q;
    code_d      = code_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    fail        = 1'b0;
    unique case (state_q)
      SEEK: begin
        if (sync_ev) begin
          state_d = ARMED;
          idx_d   = '0;
        end
      end
      ARMED: begin
        if (rise) state_d = HIGH;
      end
      HIGH: begin
        if (fall) begin
          hcls_d = cur_cls;
          if (cur_cls == C_BAD)
            fail = 1'b1;
          else if (idx_q == 5'd24) begin
            if (cur_cls == C_SHORT)
              state_d = WORD;
            else
              fail = 1'b1;
          end else
            state_d = LOW;
        end
      end
      LOW: begin
        if (rise) begin
          // second half of a symbol: "ba" has no meaning
          if (!pulse_ok || (idx_q[0] && hb_q && !half))
            fail = 1'b1;
          else begin
            hb_d    = half;
            idx_d   = idx_q + 5'd1;
            state_d = HIGH;
            if (idx_q[0])
              word_d[{idx_q[4:1], 1'b0} +: 2] = {hb_q, half};
          end
        end else if (lo_to)
          fail = 1'b1;
      end
      WORD: begin
        if (rise)
          fail = 1'b1;
        else if (sync_ev) begin
          if (prev_ok_q && word_q == prev_word_q) begin
            code_d  = word_q;
            valid_d = 1'b1;
          end
          prev_word_d = word_q;
          prev_ok_d   = 1'b1;
          state_d     = ARMED;
          idx_d       = '0;
        end
      end
      default: state_d = SEEK;
    endcase
    if (fail) begin
      err_d     = 1'b1;
      prev_ok_d = 1'b0;
      state_d   = SEEK;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q        <= 1'b0;
      ds_q        <= 1'b0;
      dsp_q       <= 1'b0;
      cnt_q       <= '0;
      state_q     <= SEEK;
      idx_q       <= '0;
      hcls_q      <= C_BAD;
      hb_q        <= 1'b0;
      word_q      <= '0;
      prev_word_q <= '0;
      prev_ok_q   <= 1'b0;
      code_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      s1_q        <= bus.din;
      ds_q        <= s1_q;
      dsp_q       <= ds_q;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      hcls_q      <= hcls_d;
      hb_q        <= hb_d;
      word_q      <= word_d;
      prev_word_q <= prev_word_d;
      prev_ok_q   <= prev_ok_d;
      code_q      <= code_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.code  = code_q;
  assign bus.valid = valid_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_pt_rx_decoder.sv
// Bench for pt_rx_decoder: phase-level decode model plus directed words.
// Drives bus.din as timed high/low phases; checks outputs every cycle.
module tb_pt_rx_decoder;

  localparam int A = 4;
  localparam int SHORT = 1;
  localparam int LONG  = 2;
  localparam int BAD   = 0;

  localparam logic [23:0] W1 = 24'h71C71C;
  localparam logic [23:0] WX = 24'h000000;
  localparam logic [23:0] WY = 24'h000C00;
  localparam logic [23:0] WZ = 24'hFFFFFF;
  localparam logic [23:0] WB = 24'h71C79C;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   vec = 0;
  int   mis = 0;
  int   n_valid = 0;
  int   n_err = 0;
  bit   chk_en = 1'b0;
  int   bhi = 12*A;

  pt_rx_decoder_if bus();

  pt_rx_decoder #(.ALPHA(A)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bit          hunting = 1'b1;
  bit          await_sync = 1'b0;
  int          hw = 0;
  bit          hb[$];
  logic [23:0] pw = '0;
  bit          pok = 1'b0;
  bit          exp_valid[int];
  bit          exp_err[int];
  logic [23:0] code_chg[int];
  logic [23:0] exp_code = '0;

  function automatic int cls(int w);
    if (w < 2*A || w >= 16*A) return BAD;
    if (w < 8*A) return SHORT;
    return LONG;
  endfunction

  function automatic logic [23:0] pack_word();
    logic [23:0] w;
    w = '0;
    for (int i = 0; i < 12; i++) begin
      if (!hb[2*i] && !hb[2*i+1])
        w[2*i +: 2] = 2'b00;
      else if (hb[2*i] && hb[2*i+1])
        w[2*i +: 2] = 2'b11;
      else
        w[2*i +: 2] = 2'b01;
    end
    return w;
  endfunction

  task automatic model_err(int t);
    exp_err[t] = 1'b1;
    pok = 1'b0;
    hunting = 1'b1;
    await_sync = 1'b0;
  endtask

  task automatic model_reset(int t);
    hunting = 1'b1;
    await_sync = 1'b0;
    pok = 1'b0;
    pw = '0;
    hb.delete();
    code_chg[t] = '0;
  endtask

  // One phase of level lvl, len cycles, din changed just after edge k.
  // Outputs reflecting a line event show up 3 edges later.
  task automatic model_phase(bit lvl, int len, int k);
    int c;
    bit h;
    logic [23:0] w;
    int t;
    if (hunting) begin
      if (!lvl && len > 64*A) begin
        hunting = 1'b0;
        hb.delete();
      end
      return;
    end
    if (lvl) begin
      c = cls(len);
      if (hb.size() == 24) begin
        if (c == SHORT) await_sync = 1'b1;
        else model_err(k + len + 3);
      end else if (c == BAD)
        model_err(k + len + 3);
      else
        hw = c;
    end else if (await_sync) begin
      await_sync = 1'b0;
      if (len > 64*A) begin
        w = pack_word();
        t = k + 64*A + 3;
        if (pok && w == pw) begin
          exp_valid[t] = 1'b1;
          code_chg[t] = w;
        end
        pw = w;
        pok = 1'b1;
        hb.delete();
      end else
        model_err(k + len + 3);
    end else if (len > 16*A) begin
      model_err(k + 16*A + 3);
      if (len > 64*A) begin
        hunting = 1'b0;
        hb.delete();
      end
    end else begin
      c = cls(len);
      if (hw == SHORT && c == LONG) h = 1'b0;
      else if (hw == LONG && c == SHORT) h = 1'b1;
      else begin
        model_err(k + len + 3);
        return;
      end
      if ((hb.size() % 2) == 1 && hb[hb.size()-1] && !h) begin
        model_err(k + len + 3);
        return;
      end
      hb.push_back(h);
    end
  endtask

  always @(negedge clk) begin
    bit ev, ee;
    if (chk_en) begin
      if (code_chg.exists(cyc)) exp_code = code_chg[cyc];
      ev = exp_valid.exists(cyc);
      ee = exp_err.exists(cyc);
      vec++;
      if (bus.valid !== ev || bus.err !== ee || bus.code !== exp_code) begin
        mis++;
        $display("FAIL cycle %0d: valid=%b err=%b code=%h, want valid=%b err=%b code=%h",
                 cyc, bus.valid, bus.err, bus.code, ev, ee, exp_code);
      end
      if (bus.valid === 1'b1) n_valid++;
      if (bus.err === 1'b1) n_err++;
    end
  end

  task automatic check(string name, logic [23:0] got, logic [23:0] want);
    vec++;
    if (got !== want) begin
      mis++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic ph(bit lvl, int len);
    bus.din = lvl;
    model_phase(lvl, len, cyc);
    repeat (len) @(posedge clk);
    #1;
  endtask

  task automatic pulse(bit b);
    if (b) begin
      ph(1'b1, bhi);
      ph(1'b0, 4*A);
    end else begin
      ph(1'b1, 4*A);
      ph(1'b0, 12*A);
    end
  endtask

  task automatic send_syms(logic [23:0] w, int nsym);
    for (int i = 0; i < nsym; i++) begin
      pulse(w[2*i+1]);
      pulse(w[2*i]);
    end
  endtask

  task automatic send_word(logic [23:0] w, int nsym);
    send_syms(w, nsym);
    ph(1'b1, 4*A);
    ph(1'b0, 70*A);
  endtask

  int v0, e0;

  task automatic mark();
    v0 = n_valid;
    e0 = n_err;
  endtask

  initial begin
    bus.din = 1'b0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    reset = 1'b1;
    check("rst_code", bus.code, 24'h0);
    check("rst_valid", {23'b0, bus.valid}, 24'h0);
    check("rst_err", {23'b0, bus.err}, 24'h0);

    // three identical words after an initial sync
    mark();
    ph(1'b0, 70*A);
    repeat (3) send_word(W1, 12);
    check("w3_nvalid", n_valid - v0, 2);
    check("w3_nerr", n_err - e0, 0);
    check("w3_code", bus.code, 24'h71C71C);
    check("model_word", pw, 24'h71C71C);

    // words differing in symbol 5
    mark();
    send_word(WX, 12);
    send_word(WY, 12);
    check("diff_nvalid", n_valid - v0, 0);
    send_word(WY, 12);
    check("same_nvalid", n_valid - v0, 1);
    check("same_code", bus.code, 24'h000C00);

    // "ba" at symbol 3, then recovery
    mark();
    send_word(WB, 12);
    check("ba_nerr", n_err - e0, 1);
    check("ba_nvalid", n_valid - v0, 0);
    send_word(W1, 12);
    send_word(W1, 12);
    check("ba_rec_nvalid", n_valid - v0, 1);

    // 8a high decodes as LONG
    mark();
    bhi = 8*A;
    send_word(WZ, 12);
    send_word(WZ, 12);
    bhi = 12*A;
    check("hi8_nvalid", n_valid - v0, 1);
    check("hi8_code", bus.code, 24'hFFFFFF);
    // 16a high, 1a glitch, 16a low
    ph(1'b1, 16*A);
    ph(1'b0, 70*A);
    ph(1'b1, A);
    ph(1'b0, 70*A);
    ph(1'b1, 4*A);
    ph(1'b0, 16*A);
    ph(1'b1, 4*A);
    ph(1'b0, 70*A);
    check("bnd_nerr", n_err - e0, 3);

    // reset inside symbol 7, then a 1000a low
    mark();
    send_syms(W1, 7);
    bus.din = 1'b1;
    repeat (2*A) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset(cyc + 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    check("mid_rst_code", bus.code, 24'h0);
    check("mid_rst_valid", {23'b0, bus.valid}, 24'h0);
    repeat (2*A) @(posedge clk);
    #1;
    ph(1'b0, 1000*A);
    check("hold_nerr", n_err - e0, 0);
    check("hold_nvalid", n_valid - v0, 0);
    send_word(W1, 12);
    send_word(W1, 12);
    check("rst_rec_nvalid", n_valid - v0, 1);
    check("rst_rec_code", bus.code, 24'h71C71C);

    // truncated word: 10 symbols then sync
    mark();
    send_word(W1, 10);
    check("trunc_nerr", n_err - e0, 1);
    send_word(W1, 12);
    send_word(W1, 12);
    check("trunc_nvalid", n_valid - v0, 1);

    repeat (20) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
